// File: rtl/instr_fetch_unit_if.sv
// Bundles the instruction-memory request/response channel, the redirect input and
// the decode-side valid/ready handshake of instr_fetch_unit.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus1;

  // The fetch unit drives the memory request and the decode-side payload.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus1,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus1,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: credit-limited pipelined imem requests, prefetch FIFO with PCs,
// redirect flush with in-flight discard. Define IFETCH_BYPASS_EN for empty-FIFO bypass.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               CLK,
  input logic               RST,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

`ifdef IFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [31:0] fpc;
  logic [31:0] rpc;
  cnt_t        occ;
  cnt_t        outstanding;
  cnt_t        discard;
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc   [DEPTH];

  logic [CW:0] committed;
  logic        credit_ok;
  logic        req;
  logic        accept;
  logic        keep;
  logic        fifo_empty;
  logic        bypass;
  logic        push;
  logic        pop;
  logic        valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // NOTE: every signal in a combinational block gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    committed  = (CW+1)'(occ) + (CW+1)'(outstanding);
    credit_ok  = committed < (CW+1)'(DEPTH);
    req        = RST & ~bus.redirect & credit_ok;
    accept     = req & bus.imem_gnt;
    keep       = bus.imem_rvalid & (discard == '0) & ~bus.redirect;
    fifo_empty = (occ == '0);
    bypass     = BYPASS & keep & fifo_empty;
    valid      = ~fifo_empty | bypass;
    pop        = ~fifo_empty & bus.instr_ready & ~bus.redirect;
    // A bypassed word that decode takes this cycle never enters the FIFO.
    push       = keep & ~(bypass & bus.instr_ready);

    out_instr = '0;
    out_pc    = '0;
    if (bypass) begin
      out_instr = bus.imem_rdata;
      out_pc    = rpc;
    end else if (!fifo_empty) begin
      out_instr = mem_data[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
    end
  end

  always_comb begin
    bus.imem_req       = req;
    bus.imem_addr      = fpc;
    bus.instr_valid    = valid;
    bus.instr          = out_instr;
    bus.instr_pc       = out_pc;
    bus.instr_pc_plus1 = valid ? out_pc + 32'd1 : 32'd0;
  end

  // NOTE: state registers use non-blocking assignments so every update in this block
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (bus.redirect) begin
      // Everything still in flight becomes garbage; the response arriving now is one of them.
      fpc         <= bus.redirect_pc;
      rpc         <= bus.redirect_pc;
      occ         <= '0;
      rd_ptr      <= wr_ptr;
      outstanding <= outstanding - CW'(bus.imem_rvalid);
      discard     <= discard + outstanding - CW'(bus.imem_rvalid);
    end else begin
      if (accept) fpc <= fpc + 32'd1;
      if (keep)   rpc <= rpc + 32'd1;
      outstanding <= outstanding + CW'(accept) - CW'(bus.imem_rvalid);
      if (bus.imem_rvalid && discard != '0) discard <= discard - CW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; occ gates every read, so stale contents are
  // never observable and the array can map onto plain flops or a register file.
  always_ff @(posedge CLK) begin
    if (push && !bus.redirect) begin
      mem_data[wr_ptr] <= bus.imem_rdata;
      mem_pc[wr_ptr]   <= rpc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build, DEPTH=4, RESET_PC=0) with an
// in-order imem model that answers one cycle after each grant.
module tb_instr_fetch_unit;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          grants   = 0;
  bit          auto_resp;
  logic [31:0] pending [$];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_resp();
    if (auto_resp && pending.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pending[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  // One clock: record what the edge will see, advance, update the memory model.
  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      logic        g;
      logic        r;
      logic [31:0] a;
      g = bus.imem_req & bus.imem_gnt;
      r = bus.imem_rvalid;
      a = bus.imem_addr;
      @(posedge CLK);
      @(negedge CLK);
      if (r) void'(pending.pop_front());
      if (g) begin
        pending.push_back(a);
        grants++;
      end
      drive_resp();
      #1;
    end
  endtask

  task automatic do_reset();
    RST             = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    auto_resp       = 1'b0;
    pending.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  task automatic wait_valid(string tag, int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.instr_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst imem_req", 32'(bus.imem_req), 32'd0);
    check("rst imem_addr", bus.imem_addr, 32'h0);
    check("rst instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst instr", bus.instr, 32'h0);
    check("rst instr_pc", bus.instr_pc, 32'h0);
    check("rst instr_pc_plus1", bus.instr_pc_plus1, 32'h0);

    // 1: streaming, no gaps after fill
    do_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; auto_resp = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("t1 imem_addr", bus.imem_addr, 32'(k));
      check("t1 imem_req", 32'(bus.imem_req), 32'd1);
      if (k >= 2) begin
        check("t1 instr_valid", 32'(bus.instr_valid), 32'd1);
        check("t1 instr_pc", bus.instr_pc, 32'(k - 2));
        check("t1 instr_pc_plus1", bus.instr_pc_plus1, 32'(k - 1));
        check("t1 instr", bus.instr, mem_word(32'(k - 2)));
      end else begin
        check("t1 fill instr_valid", 32'(bus.instr_valid), 32'd0);
      end
      step();
    end

    // 2: credit limit with decode stalled
    do_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b0; auto_resp = 1'b1;
    grants = 0;
    #1;
    step(8);
    check("t2 grants", 32'(grants), 32'd4);
    check("t2 imem_req", 32'(bus.imem_req), 32'd0);
    check("t2 instr_pc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1; #1;
    step();
    bus.instr_ready = 1'b0; #1;
    step(6);
    check("t2 grants after pop", 32'(grants), 32'd5);
    check("t2 imem_req after pop", 32'(bus.imem_req), 32'd0);
    check("t2 imem_addr after pop", bus.imem_addr, 32'd5);
    check("t2 head pc", bus.instr_pc, 32'd1);
    check("t2 head instr", bus.instr, mem_word(32'd1));

    // 3: redirect with 3 outstanding
    do_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; auto_resp = 1'b0;
    #1;
    step(3);
    check("t3 held responses", 32'(pending.size()), 32'd3);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40; #1;
    check("t3 req during redirect", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect = 1'b0; auto_resp = 1'b1; drive_resp(); #1;
    check("t3 req after redirect", 32'(bus.imem_req), 32'd1);
    check("t3 addr after redirect", bus.imem_addr, 32'h40);
    wait_valid("t3", 20);
    check("t3 first instr_pc", bus.instr_pc, 32'h40);
    check("t3 first instr", bus.instr, mem_word(32'h40));

    // 4: redirect coincident with rvalid and a pop
    do_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; auto_resp = 1'b1;
    #1;
    step(3);
    check("t4 valid before redirect", 32'(bus.instr_valid), 32'd1);
    check("t4 pc before redirect", bus.instr_pc, 32'd1);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h80; #1;
    check("t4 req during redirect", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect = 1'b0; #1;
    check("t4 fifo empty after", 32'(bus.instr_valid), 32'd0);
    check("t4 addr after", bus.imem_addr, 32'h80);
    wait_valid("t4", 20);
    check("t4 first instr_pc", bus.instr_pc, 32'h80);
    check("t4 first instr", bus.instr, mem_word(32'h80));

    // 5: fetch PC wrap
    do_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; auto_resp = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; #1;
    step();
    bus.redirect = 1'b0; #1;
    check("t5 addr max", bus.imem_addr, 32'hFFFF_FFFF);
    step();
    check("t5 addr wrapped", bus.imem_addr, 32'h0);
    wait_valid("t5", 20);
    check("t5 instr_pc", bus.instr_pc, 32'hFFFF_FFFF);
    check("t5 instr_pc_plus1", bus.instr_pc_plus1, 32'h0);
    check("t5 instr", bus.instr, mem_word(32'hFFFF_FFFF));

    // 6: asynchronous reset mid-stream with 2 outstanding
    do_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b0; auto_resp = 1'b1;
    #1;
    step(2);
    auto_resp = 1'b0; drive_resp(); #1;
    step();
    check("t6 outstanding", 32'(pending.size()), 32'd2);
    check("t6 valid before rst", 32'(bus.instr_valid), 32'd1);
    check("t6 addr before rst", bus.imem_addr, 32'd3);
    #2;
    RST = 1'b0;
    pending.delete();
    #1;
    check("t6 rst imem_req", 32'(bus.imem_req), 32'd0);
    check("t6 rst imem_addr", bus.imem_addr, 32'h0);
    check("t6 rst instr_valid", 32'(bus.instr_valid), 32'd0);
    check("t6 rst instr", bus.instr, 32'h0);
    check("t6 rst instr_pc", bus.instr_pc, 32'h0);
    check("t6 rst instr_pc_plus1", bus.instr_pc_plus1, 32'h0);
    @(negedge CLK);
    RST = 1'b1; auto_resp = 1'b1; bus.instr_ready = 1'b1; drive_resp(); #1;
    check("t6 restart req", 32'(bus.imem_req), 32'd1);
    check("t6 restart addr", bus.imem_addr, 32'h0);
    wait_valid("t6", 20);
    check("t6 restart instr_pc", bus.instr_pc, 32'h0);
    check("t6 restart instr", bus.instr, mem_word(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
